// File: rtl/bcd_digit_sequencer.sv
// Walks a packed BCD word through one external single-digit converter, one digit per clock.
// Latency NDIG+1 cycles from accepted start to done; start is ignored while busy or done.
module bcd_digit_sequencer #(
   parameter int NDIG = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [4*NDIG-1:0] bcd_in,
   output logic              busy,
   output logic              done,
   output logic [4*NDIG-1:0] xs3_out,
   output logic [NDIG-1:0]   err_mask,
   output logic              conv_w,
   output logic              conv_x,
   output logic              conv_y,
   output logic              conv_z,
   input  logic              conv_a,
   input  logic              conv_b,
   input  logic              conv_c,
   input  logic              conv_d
);

   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [IW-1:0]     idx;
   logic [4*NDIG-1:0] operand;
   logic [3:0]        digit;

   assign digit = operand[4*idx +: 4];

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      {conv_w, conv_x, conv_y, conv_z} = 4'b0000;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            {conv_w, conv_x, conv_y, conv_z} = digit;
            if (idx == LAST_IDX) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         operand  <= '0;
         xs3_out  <= '0;
         err_mask <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  operand  <= bcd_in;
                  xs3_out  <= '0;
                  err_mask <= '0;
                  idx      <= '0;
               end
            end
            RUN: begin
               // converter result is stored as-is even for invalid digits
               xs3_out[4*idx +: 4] <= {conv_a, conv_b, conv_c, conv_d};
               err_mask[idx]       <= (digit > 4'd9);
               if (idx != LAST_IDX) idx <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
